// File: rtl/mu0_phase_sequencer.sv
// MU0 phase sequencer: instruction register plus the FETCH/EXEC1/EXEC2
// control-phase FSM. It also counts retired instructions, flags illegal
// opcodes, and halts on STP.
//
// Front-panel protocol (the only handshake in this block):
//   run  is a level. It is sampled only when an instruction retires:
//        1 means fetch the next instruction, 0 means park in IDLE.
//   step is a one-cycle pulse. It is honoured only in IDLE while run=0,
//        and starts exactly one instruction. Outside IDLE it is ignored.
//   In HALT both inputs are ignored. Only reset leaves HALT.
module mu0_phase_sequencer #(
    parameter int          COUNT_WIDTH = 16,
    parameter logic [3:0]  OP_STP      = 4'h7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   step,
    input  logic [15:0]            MEM_Q,
    output logic                   FETCH,
    output logic                   EXEC1,
    output logic                   EXEC2,
    output logic [3:0]             OP,
    output logic [11:0]            IR_ADDR,
    output logic                   HALTED,
    output logic                   ILLEGAL,
    output logic [COUNT_WIDTH-1:0] INSTR_COUNT,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC1 = 3'd2,
        S_EXEC2 = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            ir_q;
    logic                   illegal_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   retire;
    logic                   set_illegal;
    logic [3:0]             op;

    assign op = ir_q[15:12];

    // State register; reset abandons any in-flight instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode. Retirement is flagged here so that the counter
    // and the illegal flag stay in step with the FSM.
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run || step) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_EXEC1;
            end
            S_EXEC1: begin
                // LDA, ADD and SUB need a second execute cycle (memory read).
                if (op == 4'h0 || op == 4'h2 || op == 4'h3) begin
                    state_d = S_EXEC2;
                end else if (op == OP_STP) begin
                    state_d = S_HALT;
                end else begin
                    retire      = 1'b1;
                    set_illegal = (op >= 4'hB);
                    state_d     = run ? S_FETCH : S_IDLE;
                end
            end
            S_EXEC2: begin
                retire  = 1'b1;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Instruction register: loaded only at the end of FETCH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_q <= 16'h0000;
        end else if (state_q == S_FETCH) begin
            ir_q <= MEM_Q;
        end
    end

    // Sticky illegal flag and saturating retired-instruction counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (retire && (count_q != {COUNT_WIDTH{1'b1}})) begin
                count_q <= count_q + COUNT_WIDTH'(1);
            end
        end
    end

    assign FETCH       = (state_q == S_FETCH);
    assign EXEC1       = (state_q == S_EXEC1);
    assign EXEC2       = (state_q == S_EXEC2);
    assign HALTED      = (state_q == S_HALT);
    assign OP          = ir_q[15:12];
    assign IR_ADDR     = ir_q[11:0];
    assign ILLEGAL     = illegal_q;
    assign INSTR_COUNT = count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mu0_phase_sequencer.sv
// Bench for mu0_phase_sequencer. Each expected strobe cycle is queued as
// {FETCH,EXEC1,EXEC2,OP,IR_ADDR}. A monitor pops one entry for every cycle
// in which the DUT shows a strobe. Status outputs are checked directly.
module tb_mu0_phase_sequencer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic [15:0]   mem_q = 16'h0000;
  logic          fetch, exec1, exec2, halted, illegal;
  logic [3:0]    op;
  logic [11:0]   ir_addr;
  logic [CW-1:0] instr_count;
  logic [2:0]    state_dbg;

  logic [18:0]   exp_q[$];
  logic [15:0]   prog_q[$];
  logic [15:0]   mem_default = 16'h0000;
  logic          mon_en = 1'b0;
  int            checks = 0;
  int            failures = 0;

  mu0_phase_sequencer #(.COUNT_WIDTH(CW), .OP_STP(4'h7)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .MEM_Q(mem_q),
    .FETCH(fetch), .EXEC1(exec1), .EXEC2(exec2), .OP(op), .IR_ADDR(ir_addr),
    .HALTED(halted), .ILLEGAL(illegal), .INSTR_COUNT(instr_count),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // program memory model: supplies the next queued word while FETCH is high
  always @(posedge clk) begin
    #1;
    if (fetch && prog_q.size() != 0) mem_q = prog_q.pop_front();
    else mem_q = mem_default;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [18:0] got, exp;
    if (mon_en && (fetch || exec1 || exec2)) begin
      got = {fetch, exec1, exec2, op, ir_addr};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL strobe_unexpected got=%h expected=none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL strobe_trace got=%h expected=%h", got, exp);
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic f, input logic e1, input logic e2, input logic [15:0] ir);
    exp_q.push_back({f, e1, e2, ir});
  endtask

  task automatic do_reset(input int n, input logic run_val, input logic [15:0] dflt);
    rst_n = 1'b0;
    run = run_val;
    step = 1'b0;
    mem_default = dflt;
    prog_q.delete();
    tick(n);
    check("rst_strobes", {29'd0, fetch, exec1, exec2}, 32'd0);
    check("rst_op", {28'd0, op}, 32'd0);
    check("rst_addr", {20'd0, ir_addr}, 32'd0);
    check("rst_count", {28'd0, instr_count}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    mon_en = 1'b1;
  endtask

  initial begin
    tick(1);

    // Reset with run=1 and MEM_Q=2ABC, then leave reset: IDLE->FETCH
    do_reset(2, 1'b1, 16'h2ABC);
    push_exp(1, 0, 0, 16'h0000);
    push_exp(0, 1, 0, 16'h2ABC);
    push_exp(0, 0, 1, 16'h2ABC);
    rst_n = 1'b1;
    tick(1);
    check("leave_reset_fetch", {31'd0, fetch}, 32'd1);
    run = 1'b0;
    tick(4);
    check("s1_count", {28'd0, instr_count}, 32'd1);
    check("s1_queue_empty", exp_q.size(), 32'd0);

    // Free-run: LDA 010, STA 020, STP
    do_reset(1, 1'b0, 16'h0000);
    rst_n = 1'b1;
    prog_q.push_back(16'h0010);
    prog_q.push_back(16'h1020);
    prog_q.push_back(16'h7000);
    push_exp(1, 0, 0, 16'h0000);
    push_exp(0, 1, 0, 16'h0010);
    push_exp(0, 0, 1, 16'h0010);
    push_exp(1, 0, 0, 16'h0010);
    push_exp(0, 1, 0, 16'h1020);
    push_exp(1, 0, 0, 16'h1020);
    push_exp(0, 1, 0, 16'h7000);
    run = 1'b1;
    tick(10);
    check("s2_halted", {31'd0, halted}, 32'd1);
    check("s2_count", {28'd0, instr_count}, 32'd2);
    check("s2_op", {28'd0, op}, 32'd7);
    check("s2_queue_empty", exp_q.size(), 32'd0);
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom_range(0, 1));
      step = 1'($urandom_range(0, 1));
      tick(1);
      check("s2_halt_hold", {31'd0, halted}, 32'd1);
    end
    run = 1'b0;
    step = 1'b0;
    check("s2_count_after_halt", {28'd0, instr_count}, 32'd2);

    // Single-step SUB; a second step during EXEC1 is ignored
    do_reset(1, 1'b0, 16'h0000);
    rst_n = 1'b1;
    prog_q.push_back(16'h3005);
    push_exp(1, 0, 0, 16'h0000);
    push_exp(0, 1, 0, 16'h3005);
    push_exp(0, 0, 1, 16'h3005);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(1);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(4);
    check("s3_count", {28'd0, instr_count}, 32'd1);
    check("s3_queue_empty", exp_q.size(), 32'd0);

    // Drop run during EXEC1 of ADD: EXEC2 still happens, then IDLE
    do_reset(1, 1'b0, 16'h0000);
    rst_n = 1'b1;
    prog_q.push_back(16'h2004);
    push_exp(1, 0, 0, 16'h0000);
    push_exp(0, 1, 0, 16'h2004);
    push_exp(0, 0, 1, 16'h2004);
    run = 1'b1;
    tick(2);
    run = 1'b0;
    tick(5);
    check("s4_count", {28'd0, instr_count}, 32'd1);
    check("s4_queue_empty", exp_q.size(), 32'd0);

    // Reset during EXEC2 of LDA: partial instruction not counted, IR cleared
    do_reset(1, 1'b0, 16'h0000);
    rst_n = 1'b1;
    prog_q.push_back(16'h0010);
    push_exp(1, 0, 0, 16'h0000);
    push_exp(0, 1, 0, 16'h0010);
    push_exp(0, 0, 1, 16'h0010);
    run = 1'b1;
    tick(3);
    rst_n = 1'b0;
    run = 1'b0;
    tick(1);
    check("s6_count", {28'd0, instr_count}, 32'd0);
    check("s6_op", {28'd0, op}, 32'd0);
    check("s6_addr", {20'd0, ir_addr}, 32'd0);
    check("s6_strobes", {29'd0, fetch, exec1, exec2}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    check("s6_queue_empty", exp_q.size(), 32'd0);

    // Illegal opcode stream with a 4-bit counter: 18 instructions, saturates at F
    do_reset(1, 1'b0, 16'hC000);
    rst_n = 1'b1;
    push_exp(1, 0, 0, 16'h0000);
    push_exp(0, 1, 0, 16'hC000);
    for (int i = 0; i < 17; i++) begin
      push_exp(1, 0, 0, 16'hC000);
      push_exp(0, 1, 0, 16'hC000);
    end
    run = 1'b1;
    tick(3);
    check("s5_illegal_first", {31'd0, illegal}, 32'd1);
    check("s5_count_first", {28'd0, instr_count}, 32'd1);
    tick(33);
    run = 1'b0;
    tick(4);
    check("s5_count_sat", {28'd0, instr_count}, 32'hF);
    check("s5_illegal_sticky", {31'd0, illegal}, 32'd1);
    check("s5_queue_empty", exp_q.size(), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mu0_phase_sequencer.md
Name: mu0_phase_sequencer

Overview:
Control-phase generator and instruction register for the MU0 CPU; it produces the FETCH/EXEC1/EXEC2 strobes and OP[15:12] field that the control decoder consumes.
Latches the instruction word from program memory, decides whether each instruction needs one or two execute cycles, halts on STP, and supports free-run and single-step operation.
Sits between program RAM, the run/step front panel and the control decoder.

Parameters:
COUNT_WIDTH, 16, width of the retired-instruction counter
OP_STP, 4'h7, opcode that halts the sequencer

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
run  input  1  level; 1 = free-run, 0 = single-step mode
step  input  1  one-cycle pulse; starts one instruction when idle and run=0
MEM_Q  input  16  instruction word from synchronous program RAM (valid during FETCH)
FETCH  output  1  fetch-phase strobe
EXEC1  output  1  first execute-phase strobe
EXEC2  output  1  second execute-phase strobe
OP  output  4  IR[15:12], opcode to decoder
IR_ADDR  output  12  IR[11:0], operand address
HALTED  output  1  1 while in HALT state
ILLEGAL  output  1  sticky, set when opcode 4'hB..4'hF executed
INSTR_COUNT  output  COUNT_WIDTH  retired instructions, saturating

Behaviour:
- One clock, synchronous active-low reset (rst_n sampled on rising edge of clk only).
- States: IDLE, FETCH, EXEC1, EXEC2, HALT. FETCH/EXEC1/EXEC2 outputs are decoded from the state register only. At most one strobe is high. All three are 0 in IDLE and HALT.
- Reset values: state IDLE; IR = 16'h0000, so OP = 0 and IR_ADDR = 0; HALTED = 0; ILLEGAL = 0; INSTR_COUNT = 0.
- Reset mid-operation: the next edge returns to IDLE with all values above. Any partially executed instruction is abandoned and not counted.
- IDLE: go to FETCH if run=1 or step=1; otherwise stay.
- FETCH: IR <= MEM_Q at the end of the cycle. Next state is EXEC1. OP/IR_ADDR change only on this edge and are stable through EXEC1/EXEC2.
- EXEC1, by OP:
  - OP in {4'h0 LDA, 4'h2 ADD, 4'h3 SUB}: go to EXEC2, no count.
  - OP == OP_STP: go to HALT, no count.
  - Any other OP: instruction retires. INSTR_COUNT += 1. Next state is FETCH if run=1, else IDLE.
  - OP in 4'hB..4'hF: treated as a single-cycle NOP (retires as above) and ILLEGAL <= 1.
- EXEC2: instruction retires. INSTR_COUNT += 1. Next state is FETCH if run=1, else IDLE.
- HALT: HALTED = 1. The state is left only by reset; run and step are ignored.
- run is sampled at each retirement. Dropping run mid-instruction completes that instruction, then parks in IDLE.
- step is ignored outside IDLE and ignored when run=1. A step held high for several cycles in IDLE with run=0 starts one instruction per IDLE visit, i.e. one every 3–4 cycles. The bench uses single-cycle pulses.
- INSTR_COUNT saturates at all-ones; it never wraps.
- ILLEGAL clears only on reset.
- Latency in free-run: a one-exec instruction takes 2 cycles (FETCH, EXEC1); a two-exec instruction takes 3 cycles.

Test Plan:
- Reset: rst_n=0 for 2 cycles with run=1, MEM_Q=16'h2ABC → all strobes 0, OP=0, IR_ADDR=0, INSTR_COUNT=0, HALTED=0. After rst_n=1 the state goes IDLE→FETCH.
- Free-run sequence: MEM_Q supplies 16'h0010 (LDA), 16'h1020 (STA), 16'h7000 (STP) → strobe trace F,E1,E2,F,E1,F,E1 then HALT. OP shows 0,1,7. IR_ADDR shows 010, 020. INSTR_COUNT=2, HALTED=1 and stays 1 for 20 cycles with run/step toggled.
- Single-step: run=0, step pulse with MEM_Q=16'h3005 (SUB) → F,E1,E2 then IDLE, INSTR_COUNT=1. A second step pulse during E1 is ignored and produces no extra instruction.
- Drop run mid-instruction: run=1, ADD (16'h2004) in flight, run→0 during EXEC1 → EXEC2 still occurs, then IDLE, INSTR_COUNT incremented once.
- Illegal and saturation: COUNT_WIDTH=4, free-run stream of 16'hC000 → each takes 2 cycles, ILLEGAL=1 after the first EXEC1. INSTR_COUNT reaches 4'hF and holds.
- Reset during EXEC2 of LDA: rst_n=0 one cycle → IDLE next edge, count unchanged (0), IR=0.
